// File: rtl/aluctr_mc_if.sv
// Bus bundle for aluctr_mc: decode inputs, multi-cycle launch/operands and
// result/status outputs. The slave side is the block, the master side the driver.
interface aluctr_mc_if #(
  parameter int WIDTH = 32,
  parameter int CTRLW = 4
);
  logic [2:0]       ALUOp;
  logic [3:0]       Funct;
  logic [2:0]       Opcode;
  logic             start;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [CTRLW-1:0] ALUControl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output ALUOp, Funct, Opcode, start, SrcA, SrcB,
    input  ALUControl, busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  ALUOp, Funct, Opcode, start, SrcA, SrcB,
    output ALUControl, busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/aluctr_mc.sv
// ALU control decoder plus an iterative unsigned multiply/divide unit:
// one shift-add or restoring shift-subtract step per clock, WIDTH steps per op.
module aluctr_mc #(
  parameter int WIDTH = 32,
  parameter int CTRLW = 4
) (
  input  logic         clk,
  input  logic         rst,
  aluctr_mc_if.slave   bus
);
  localparam int CNTW = $clog2(WIDTH);
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [WIDTH-1:0] q_q, q_d;       // multiplier bits / quotient bits
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplicand / divisor
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [3:0]       ctrl;

  always_comb begin
    ctrl = 4'b0000;
    unique case (bus.ALUOp)
      3'b000: ctrl = 4'b0000;
      3'b001: ctrl = 4'b0010;
      3'b010: ctrl = bus.Funct;
      3'b011: ctrl = {1'b0, bus.Opcode};
      3'b100: ctrl = 4'b1000;
      3'b101: ctrl = OP_MULTU;
      3'b110: ctrl = OP_DIVU;
      default: ctrl = 4'b0000;
    endcase
  end

  assign bus.ALUControl = CTRLW'(ctrl);

  // Multiply step: add multiplicand when the current multiplier LSB is set,
  // then shift the {carry, acc, q} chain right by one.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc, mul_q;
  assign mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, opb_q} : '0);
  assign mul_acc = mul_sum[WIDTH:1];
  assign mul_q   = {mul_sum[0], q_q[WIDTH-1:1]};

  // Divide step: shift next dividend bit into the remainder, keep the
  // subtraction only when it does not go negative.
  logic [WIDTH:0]   div_shl, div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_acc, div_q;
  assign div_shl   = {acc_q, q_q[WIDTH-1]};
  assign div_trial = div_shl - {1'b0, opb_q};
  assign div_ge    = ~div_trial[WIDTH];
  assign div_acc   = div_ge ? div_trial[WIDTH-1:0] : div_shl[WIDTH-1:0];
  assign div_q     = {q_q[WIDTH-2:0], div_ge};

  logic last_step;
  assign last_step = (cnt_q == CNTW'(WIDTH-1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && ctrl == OP_MULTU) begin
          state_d = MUL;
          acc_d   = '0;
          q_d     = bus.SrcB;
          opb_d   = bus.SrcA;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else if (bus.start && ctrl == OP_DIVU) begin
          if (bus.SrcB != '0) begin
            state_d = DIV;
            acc_d   = '0;
            q_d     = bus.SrcA;
            opb_d   = bus.SrcB;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            hi_d    = bus.SrcA;
            lo_d    = '1;
            done_d  = 1'b1;
            dbz_d   = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d = mul_acc;
        q_d   = mul_q;
        cnt_d = cnt_q + CNTW'(1);
        if (last_step) begin
          state_d = DONE;
          hi_d    = mul_acc;
          lo_d    = mul_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DIV: begin
        acc_d = div_acc;
        q_d   = div_q;
        cnt_d = cnt_q + CNTW'(1);
        if (last_step) begin
          state_d = DONE;
          hi_d    = div_acc;
          lo_d    = div_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_aluctr_mc.sv
// Random and directed checks of aluctr_mc at WIDTH=32 and WIDTH=8 against
// an arithmetic reference (native *, /, %) and the decode table.
module tb_aluctr_mc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel8 = 1'b0;
  logic [2:0]  aop = 3'b000;
  logic [3:0]  fn = 4'b0000;
  logic [2:0]  opc = 3'b000;
  logic        st = 1'b0;
  logic [31:0] a = '0, b = '0;
  int          checks = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  aluctr_mc_if #(.WIDTH(32), .CTRLW(4)) b32 ();
  aluctr_mc_if #(.WIDTH(8),  .CTRLW(4)) b8 ();

  assign b32.ALUOp  = aop;
  assign b32.Funct  = fn;
  assign b32.Opcode = opc;
  assign b32.start  = st & ~sel8;
  assign b32.SrcA   = a;
  assign b32.SrcB   = b;
  assign b8.ALUOp   = aop;
  assign b8.Funct   = fn;
  assign b8.Opcode  = opc;
  assign b8.start   = st & sel8;
  assign b8.SrcA    = a[7:0];
  assign b8.SrcB    = b[7:0];

  aluctr_mc #(.WIDTH(32), .CTRLW(4)) u_dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  aluctr_mc #(.WIDTH(8),  .CTRLW(4)) u_dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

  logic        o_busy, o_done, o_dbz;
  logic [31:0] o_hi, o_lo;
  assign o_busy = sel8 ? b8.busy : b32.busy;
  assign o_done = sel8 ? b8.done : b32.done;
  assign o_dbz  = sel8 ? b8.div_by_zero : b32.div_by_zero;
  assign o_hi   = sel8 ? {24'b0, b8.hi} : b32.hi;
  assign o_lo   = sel8 ? {24'b0, b8.lo} : b32.lo;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_dec(input logic [2:0] op, input logic [3:0] f, input logic [2:0] o);
    logic [3:0] tbl [8];
    tbl = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h8, 4'hC, 4'hD, 4'h0};
    if (op == 3'd2) return f;
    if (op == 3'd3) return {1'b0, o};
    return tbl[op];
  endfunction

  task automatic dec(input logic [2:0] op, input logic [3:0] f, input logic [2:0] o);
    aop = op; fn = f; opc = o;
    #1;
    chk("alucontrol", 64'(b32.ALUControl), 64'(ref_dec(op, f, o)));
  endtask

  // Launch one op on the selected instance and check timing and result.
  task automatic run(input logic [2:0] op, input logic [3:0] f,
                     input logic [31:0] sa, input logic [31:0] sb, input bit hazard);
    logic [31:0] m, eh, el;
    logic [63:0] prod;
    logic        edbz;
    int          w, lat, nbusy, ndone;
    w = sel8 ? 8 : 32;
    m = sel8 ? 32'hFF : 32'hFFFF_FFFF;
    edbz = 1'b0;
    lat = w;
    if (ref_dec(op, f, 3'b0) == 4'hC) begin
      prod = 64'(sa & m) * 64'(sb & m);
      eh = 32'(prod >> w) & m;
      el = 32'(prod) & m;
    end else if ((sb & m) == 0) begin
      eh = sa & m; el = m; edbz = 1'b1; lat = 0;
    end else begin
      eh = (sa & m) % (sb & m);
      el = (sa & m) / (sb & m);
    end
    @(negedge clk);
    aop = op; fn = f; a = sa; b = sb; st = 1'b1;
    @(posedge clk);
    #1 st = 1'b0;
    nbusy = 0; ndone = 0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (o_busy) nbusy++;
      if (o_done) ndone++;
      a = $urandom; b = $urandom;
      st = hazard && (i == 5);
    end
    st = 1'b0;
    chk("busy_cycles", 64'(nbusy), 64'(lat));
    chk("early_done", 64'(ndone), 64'd0);
    @(negedge clk);
    chk("done", 64'(o_done), 64'd1);
    chk("busy_at_done", 64'(o_busy), 64'd0);
    chk("hi", 64'(o_hi), 64'(eh));
    chk("lo", 64'(o_lo), 64'(el));
    chk("dbz", 64'(o_dbz), 64'(edbz));
    @(negedge clk);
    chk("done_pulse", 64'(o_done), 64'd0);
    chk("no_requeue", 64'(o_busy), 64'd0);
    chk("dbz_clear", 64'(o_dbz), 64'd0);
    chk("hi_hold", 64'(o_hi), 64'(eh));
    chk("lo_hold", 64'(o_lo), 64'(el));
  endtask

  initial begin
    logic [2:0] rop;
    logic [3:0] rfn;
    #3;
    chk("rst_busy", 64'(b32.busy), 64'd0);
    chk("rst_done", 64'(b32.done), 64'd0);
    chk("rst_hi", 64'(b32.hi), 64'd0);
    chk("rst_lo", 64'(b32.lo), 64'd0);
    chk("rst_dbz", 64'(b32.div_by_zero), 64'd0);
    chk("rst8_busy", 64'(b8.busy), 64'd0);
    dec(3'b011, 4'h0, 3'b101);
    dec(3'b010, 4'h7, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    dec(3'b100, 4'h0, 3'b000);
    dec(3'b111, 4'hF, 3'b111);
    dec(3'b101, 4'h0, 3'b000);
    dec(3'b110, 4'h0, 3'b000);
    for (int i = 0; i < 24; i++)
      dec(3'($urandom), 4'($urandom), 3'($urandom));

    // start on single-cycle codes must not launch anything
    for (int i = 0; i < 6; i++) begin
      do begin
        rop = 3'($urandom); rfn = 4'($urandom);
      end while (ref_dec(rop, rfn, 3'b0) inside {4'hC, 4'hD});
      if (i == 0) rop = 3'b000;
      @(negedge clk);
      aop = rop; fn = rfn; st = 1'b1;
      @(posedge clk);
      #1 st = 1'b0;
      @(negedge clk);
      chk("single_busy", 64'(o_busy), 64'd0);
      chk("single_done", 64'(o_done), 64'd0);
    end

    run(3'b101, 4'h0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run(3'b110, 4'h0, 32'd100, 32'd7, 1'b0);
    run(3'b110, 4'h0, 32'd5, 32'd0, 1'b0);
    run(3'b101, 4'h0, $urandom, $urandom, 1'b1);
    run(3'b110, 4'h0, $urandom, $urandom_range(1, 1000), 1'b1);
    run(3'b010, 4'hC, $urandom, $urandom, 1'b0);
    run(3'b010, 4'hD, $urandom, $urandom, 1'b0);
    run(3'b110, 4'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 8; i++)
      run(($urandom % 2) ? 3'b101 : 3'b110, 4'h0, $urandom,
          ($urandom % 4 == 0) ? 32'd0 : $urandom, 1'b0);

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    aop = 3'b101; a = 32'hDEAD_BEEF; b = 32'h1357_9BDF; st = 1'b1;
    @(posedge clk);
    #1 st = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(b32.busy), 64'd0);
    chk("abort_hi", 64'(b32.hi), 64'd0);
    chk("abort_lo", 64'(b32.lo), 64'd0);
    chk("abort_done", 64'(b32.done), 64'd0);
    @(negedge clk);
    dec(3'b110, 4'h0, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3 * 32; i++) begin
      @(negedge clk);
      if (o_done || o_busy) begin
        chk("after_abort_idle", {62'd0, o_busy, o_done}, 64'd0);
        break;
      end
    end
    run(3'b101, 4'h0, 32'd3, 32'd4, 1'b0);

    sel8 = 1'b1;
    run(3'b101, 4'h0, 32'd255, 32'd255, 1'b0);
    run(3'b110, 4'h0, 32'd200, 32'd7, 1'b0);
    run(3'b110, 4'h0, 32'd9, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      run(($urandom % 2) ? 3'b101 : 3'b110, 4'h0, $urandom, $urandom, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
